// File: rtl/multi_line_buffer.sv
// ---------------------------------------------------------------------------
// multi_line_buffer
//   Streaming line buffer for raster video. Keeps LINES previous lines in
//   line memories that share one column pointer, and for every accepted
//   pixel presents a vertical column of LINES+1 pixels (the new pixel plus
//   the pixels directly above it) one cycle later.
//
//   Optional feature macro: LINE_BUFFER_EDGE_REPLICATE_EN
//     undefined : output only once LINES full lines have been stored.
//     defined   : output for every pixel; rows above the top of the frame
//                 are filled by replicating the topmost available row.
//
// Parameters
//   DEPTH  pixels per line (>= 2)
//   DW     bits per pixel
//   LINES  number of stored previous lines (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   sof        start of frame, qualified by input accept
//   in_valid   in_data valid
//   in_ready   block can accept in_data
//   in_data    incoming pixel, raster order
//   out_valid  out_taps/out_col/out_eol valid
//   out_ready  downstream accepts output
//   out_taps   vertical column, tap k at [(k+1)*DW-1:k*DW], tap 0 = newest
//   out_col    column index of out_taps
//   out_eol    high when out_col == DEPTH-1
// ---------------------------------------------------------------------------
module multi_line_buffer #(
  parameter int DEPTH = 960,
  parameter int DW    = 24,
  parameter int LINES = 3,
  localparam int CW   = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sof,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(LINES+1)*DW-1:0] out_taps,
  output logic [CW-1:0]           out_col,
  output logic                    out_eol
);

  localparam int RW = $clog2(LINES + 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row_cnt;
  logic [DW-1:0] mem [LINES][DEPTH];

  logic                    accept;
  logic [CW-1:0]           col_p0;
  logic [RW-1:0]           row_p0;
  logic                    wrap_p0;
  logic                    produce_p0;
  logic [(LINES+1)*DW-1:0] taps_p0;

  // ---- stage 0: accept, sof adjustment and tap gathering ----
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // sof restarts the frame on this very pixel, so it sees column 0 / row 0.
  assign col_p0  = sof ? '0 : col;
  assign row_p0  = sof ? '0 : row_cnt;
  assign wrap_p0 = (col_p0 == CW'(DEPTH - 1));

`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
  logic [DW-1:0] edge_px;

  // edge_px is the topmost row actually written since the frame started;
  // taps above it repeat it so that stale memory content never leaks out.
  always_comb begin
    edge_px = in_data;
    for (int j = 0; j < LINES; j++) begin
      if (row_p0 == RW'(j + 1)) edge_px = mem[j][col_p0];
    end
    taps_p0 = '0;
    taps_p0[DW-1:0] = in_data;
    for (int k = 1; k <= LINES; k++) begin
      if (RW'(k) > row_p0) taps_p0[k*DW +: DW] = edge_px;
      else                 taps_p0[k*DW +: DW] = mem[k-1][col_p0];
    end
  end

  assign produce_p0 = 1'b1;
`else
  always_comb begin
    taps_p0 = '0;
    taps_p0[DW-1:0] = in_data;
    for (int k = 1; k <= LINES; k++) begin
      taps_p0[k*DW +: DW] = mem[k-1][col_p0];
    end
  end

  assign produce_p0 = (row_p0 == RW'(LINES));
`endif

  // Line memories behave as a vertical shift register per column.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[0][col_p0] <= in_data;
      for (int k = 1; k < LINES; k++) begin
        mem[k][col_p0] <= mem[k-1][col_p0];
      end
    end
  end

  // Column pointer and row fill count; row_cnt saturates at LINES.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col     <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (wrap_p0) begin
        col     <= '0;
        row_cnt <= (row_p0 == RW'(LINES)) ? row_p0 : row_p0 + RW'(1);
      end else begin
        col     <= col_p0 + CW'(1);
        row_cnt <= row_p0;
      end
    end
  end

  // ---- stage 1: output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (accept && produce_p0) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_taps <= '0;
      out_col  <= '0;
      out_eol  <= 1'b0;
    end else if (accept && produce_p0) begin
      out_taps <= taps_p0;
      out_col  <= col_p0;
      out_eol  <= wrap_p0;
    end
  end

endmodule

// File: doc/multi_line_buffer.md
MULTI_LINE_BUFFER -- requirements
Module: multi_line_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 960: pixels per line, minimum 2.
REQ-002 SHALL have parameter DW, default 24: bits per pixel.
REQ-003 SHALL have parameter LINES, default 3: number of stored previous lines, minimum 1.
REQ-004 SHALL derive local CW = max(1, clog2(DEPTH)) for column width.
REQ-005 SHALL use one clock; reset is synchronous and active-low, with ports named clk and rst_n.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 sof  in  1  start-of-frame, qualified by input accept.
REQ-009 in_valid  in  1  in_data valid.
REQ-010 in_ready  out  1  block can accept in_data.
REQ-011 in_data  in  DW  incoming pixel, raster order.
REQ-012 out_valid  out  1  out_taps/out_col/out_eol valid.
REQ-013 out_ready  in  1  downstream accepts output.
REQ-014 out_taps  out  (LINES+1)*DW  vertical column; tap k at bits [(k+1)*DW-1:k*DW], tap 0 = newest line.
REQ-015 out_col  out  CW  column index of out_taps.
REQ-016 out_eol  out  1  high when out_col == DEPTH-1.

Function
REQ-017 Accept SHALL occur when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-018 Storage SHALL be LINES line memories of DEPTH x DW, sharing one column pointer col.
REQ-019 On accept at column c: tap0 = in_data, tapk = mem[k-1][c]; then mem[0][c] <= in_data, mem[k][c] <= mem[k-1][c].
REQ-020 Latency SHALL be 1 cycle: taps registered into the output stage on the accept edge.
REQ-021 col SHALL increment per accept and wrap from DEPTH-1 to 0; row_cnt SHALL increment on that wrap, saturating at LINES.
REQ-022 Accept with sof=1 SHALL treat the pixel as col 0, row_cnt 0, discarding any partial line.
REQ-023 No accept SHALL leave col, row_cnt, memories and output register unchanged.
REQ-024 Output SHALL hold stable while out_valid && !out_ready.
REQ-025 out_valid SHALL clear on out_ready with no new output-producing accept; same-cycle out_ready and accept SHALL replace contents with out_valid staying 1.
REQ-026 Accepts in rows lacking a valid output (REQ-030) SHALL update storage and not set out_valid.

Reset
REQ-027 On rst_n=0 at clk edge: col=0, row_cnt=0, out_valid=0, out_taps=0, out_col=0, out_eol=0.
REQ-028 Line memory contents SHALL NOT be reset; reset mid-line SHALL discard the partial line and fill state.
REQ-029 in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-030 Without LINE_BUFFER_EDGE_REPLICATE_EN: output produced only for accepts with row_cnt == LINES (after sof adjustment).
REQ-031 With LINE_BUFFER_EDGE_REPLICATE_EN: output for every accept; tapk with k > row_cnt SHALL equal tap[row_cnt] (top-edge replication).

Verification
REQ-032 DEPTH=4,DW=8,LINES=2, no macro; 12 pixels 1..12, out_ready=1 -> outputs only for pixels 9..12: {tap0,tap1,tap2}={9,5,1}..{12,8,4}, out_col 0..3, out_eol on 12.
REQ-033 Same with macro -> 12 outputs; pixel 1 {1,1,1}, pixel 5 {5,1,1}, pixel 9 {9,5,1}.
REQ-034 out_ready=0 after first output, in_valid=1 -> in_ready=0, output held 3 cycles unchanged; out_ready=1 -> next pixel accepted same cycle, out_valid stays 1.
REQ-035 sof=1 on pixel 7 mid-line -> col resets, no output (no macro) until 8 more pixels after pixel 7.
REQ-036 rst_n=0 for one cycle mid-line 2 -> out_valid=0, out_taps=0; restart needs LINES full lines before first output.
REQ-037 in_valid toggling 1/0 each cycle, random out_ready -> output sequence identical to REQ-032, no drops or duplicates.
